bridge_req_tx: RTL

BRIDGE_REQ_TX -- requirements
Module: bridge_req_tx

---
 rtl/bridge_req_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/bridge_req_tx.sv
// Bus request to ASCII frame encoder.
// Read frame:  'M' + 4 hex address digits + CR LF               (7 bytes)
// Write frame: 'M' + 4 hex address digits + 4 hex data digits + CR LF (11 bytes)
// The request is latched on acceptance, so later input changes cannot disturb the frame.
module bridge_req_tx #(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        rw_q;

  logic [3:0]  idx_next;
  logic [3:0]  idx_last;
  logic [7:0]  next_byte;

  // Map a nibble to its ASCII hex digit
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] alpha_base;
    alpha_base = UPPERCASE ? 8'h41 : 8'h61;
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = alpha_base + {4'h0, n} - 8'd10;
  endfunction

  // Byte at a given frame position; MS nibble first
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [15:0] addr,
                                            input logic [15:0] wdata,
                                            input logic        rw);
    case (idx)
      4'd0:    frame_byte = 8'h4D;
      4'd1:    frame_byte = hex_char(addr[15:12]);
      4'd2:    frame_byte = hex_char(addr[11:8]);
      4'd3:    frame_byte = hex_char(addr[7:4]);
      4'd4:    frame_byte = hex_char(addr[3:0]);
      4'd5:    frame_byte = rw ? hex_char(wdata[15:12]) : 8'h0D;
      4'd6:    frame_byte = rw ? hex_char(wdata[11:8])  : 8'h0A;
      4'd7:    frame_byte = hex_char(wdata[7:4]);
      4'd8:    frame_byte = hex_char(wdata[3:0]);
      4'd9:    frame_byte = 8'h0D;
      4'd10:   frame_byte = 8'h0A;
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Next byte to present once the current one transfers
  always_comb begin
    idx_next  = idx_q + 4'd1;
    idx_last  = rw_q ? 4'd10 : 4'd6;
    next_byte = frame_byte(idx_next, addr_q, wdata_q, rw_q);
  end

  // Frame sequencer with registered handshake and data outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rw_q    <= 1'b0;
      ready_o <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          data_o  <= 8'h00;
          // ready_o is registered, so nothing is accepted on the first edge out of reset
          if (valid_i && ready_o) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            rw_q    <= rw_i;
            idx_q   <= 4'd0;
            state_q <= StSend;
            ready_o <= 1'b0;
            valid_o <= 1'b1;
            data_o  <= 8'h4D;
          end
        end
        StSend: begin
          if (ready_i) begin
            if (idx_q == idx_last) begin
              state_q <= StIdle;
              idx_q   <= 4'd0;
              valid_o <= 1'b0;
              data_o  <= 8'h00;
              ready_o <= 1'b1;
            end else begin
              idx_q  <= idx_next;
              data_o <= next_byte;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
